// File: rtl/add_round_key_unit_pkg.sv
// add_round_key_unit_pkg: AES-128 constants, types, S-box and key-schedule helpers
package add_round_key_unit_pkg;
  localparam int AES_NR = 10;
  localparam logic [7:0] RCON_ENC = 8'h01;
  localparam logic [7:0] RCON_DEC = 8'h36;
  typedef logic [127:0] state_t;
  typedef logic [31:0] word_t;
  typedef enum logic {NO_KEY, RUN} fsm_t;
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // walks the rcon sequence backwards; 0x1b is the one step that wraps the reduction
  function automatic logic [7:0] inv_rcon(input logic [7:0] r);
    return r == 8'h1b ? 8'h80 : r >> 1;
  endfunction
  function automatic word_t word_of(input state_t s, input int c);
    return s[127-32*c -: 32];
  endfunction
endpackage

// File: rtl/add_round_key_unit_if.sv
// add_round_key_unit_if: state in/out valid-ready handshake bundle
interface add_round_key_unit_if;
  import add_round_key_unit_pkg::*;
  logic in_valid;
  logic in_ready;
  state_t state_in;
  logic out_valid;
  logic out_ready;
  state_t state_out;
  logic [3:0] round_idx;
  logic last_round;
  modport master (output in_valid, state_in, out_ready, input in_ready, out_valid, state_out, round_idx, last_round);
  modport slave (input in_valid, state_in, out_ready, output in_ready, out_valid, state_out, round_idx, last_round);
endinterface

// File: rtl/add_round_key_unit_key_step.sv
// add_round_key_unit_key_step: one forward (dir=1) or inverse (dir=0) AES-128 key-schedule step
module add_round_key_unit_key_step
  import add_round_key_unit_pkg::*;
(
  input  state_t     key,
  input  logic [7:0] rcon,
  input  logic       dir,
  output state_t     next_key
);
  word_t w0, w1, w2, w3, p1, p2, p3, rot, sub, t, f0, f1, f2, f3;
  always_comb begin
    w0 = word_of(key, 0);
    w1 = word_of(key, 1);
    w2 = word_of(key, 2);
    w3 = word_of(key, 3);
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    rot = dir ? {w3[23:0], w3[31:24]} : {p3[23:0], p3[31:24]};
  end
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub[8*i +: 8] = sbox_lookup(rot[8*i +: 8]);
  end
  always_comb begin
    t = sub ^ {rcon, 24'h0};
    f0 = w0 ^ t;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    next_key = dir ? {f0, f1, f2, f3} : {w0 ^ t, p1, p2, p3};
  end
endmodule

// File: rtl/add_round_key_unit.sv
// add_round_key_unit: iterative AES-128 AddRoundKey with on-the-fly key schedule
module add_round_key_unit
  import add_round_key_unit_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   encrypt,
  input  logic   key_load,
  input  state_t key_in,
  add_round_key_unit_if.slave bus
);
  localparam logic [3:0] NR4 = 4'(NUM_ROUNDS);
  fsm_t fsm_q, fsm_d;
  logic mode_q, mode_d, out_valid_q, out_valid_d, last_round_q, last_round_d;
  logic [3:0] cnt_q, cnt_d, round_idx_q, round_idx_d;
  logic [7:0] rcon_q, rcon_d;
  state_t cur_key_q, cur_key_d, saved_key_q, saved_key_d, state_out_q, state_out_d, next_key;
  logic in_ready, accept, last;
  add_round_key_unit_key_step u_step (.key(cur_key_q), .rcon(rcon_q), .dir(mode_q), .next_key(next_key));
  always_comb begin
    in_ready = fsm_q == RUN && !key_load && (!out_valid_q || bus.out_ready);
    accept = bus.in_valid && in_ready;
    last = mode_q ? cnt_q == NR4 : cnt_q == 4'd0;
    fsm_d = fsm_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    rcon_d = rcon_q;
    cur_key_d = cur_key_q;
    saved_key_d = saved_key_q;
    out_valid_d = out_valid_q;
    state_out_d = state_out_q;
    round_idx_d = round_idx_q;
    last_round_d = last_round_q;
    if (key_load) begin
      fsm_d = RUN;
      mode_d = encrypt;
      cur_key_d = key_in;
      saved_key_d = key_in;
      cnt_d = encrypt ? 4'd0 : NR4;
      rcon_d = encrypt ? RCON_ENC : RCON_DEC;
      out_valid_d = 1'b0;
      last_round_d = 1'b0;
    end else if (accept) begin
      state_out_d = bus.state_in ^ cur_key_q;
      round_idx_d = cnt_q;
      out_valid_d = 1'b1;
      last_round_d = last;
      // the final round of a block rewinds to the loaded key so the next block needs no reload
      cur_key_d = last ? saved_key_q : next_key;
      cnt_d = last ? (mode_q ? 4'd0 : NR4) : (mode_q ? cnt_q + 4'd1 : cnt_q - 4'd1);
      rcon_d = last ? (mode_q ? RCON_ENC : RCON_DEC) : (mode_q ? xtime(rcon_q) : inv_rcon(rcon_q));
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= NO_KEY;
      mode_q <= 1'b0;
      cnt_q <= 4'd0;
      rcon_q <= 8'h00;
      cur_key_q <= '0;
      saved_key_q <= '0;
      out_valid_q <= 1'b0;
      state_out_q <= '0;
      round_idx_q <= 4'd0;
      last_round_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      rcon_q <= rcon_d;
      cur_key_q <= cur_key_d;
      saved_key_q <= saved_key_d;
      out_valid_q <= out_valid_d;
      state_out_q <= state_out_d;
      round_idx_q <= round_idx_d;
      last_round_q <= last_round_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = state_out_q;
  assign bus.round_idx = round_idx_q;
  assign bus.last_round = last_round_q;
endmodule
